fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 20 ++
 rtl/fwd_scoreboard_sb_entry.sv | 50 +++++
 rtl/fwd_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: register address width
// and the per-port operand source encoding.
package fwd_scoreboard_pkg;

    localparam int RS_WIDTH = 5;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_BYP  = 2'b01,
        FWD_WAIT = 2'b10
    } fwd_sel_e;

    // Operand source for one register given its pending bit and countdown state.
    function automatic fwd_sel_e fwd_decode(input logic pend, input logic cnt_zero);
        if (!pend)    return FWD_RF;
        if (cnt_zero) return FWD_BYP;
        return FWD_WAIT;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_sb_entry.sv
// One scoreboard entry: pending flag plus a saturating countdown to the
// cycle the producer's result appears on the bypass network.
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             wb_clr_i,
    input  logic             flush_i,
    output logic             pend_o,
    output logic [LAT_W-1:0] cnt_o
);

    logic             pend_q, pend_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Priority rises down the block: flush beats a new issue, which beats writeback.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (pend_q && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
        if (wb_clr_i) pend_d = 1'b0;
        if (load_i) begin
            pend_d = 1'b1;
            cnt_d  = lat_i;
        end
        if (flush_i) begin
            pend_d = 1'b0;
            cnt_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o = pend_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Register scoreboard that picks regfile/bypass/wait per operand port and
// raises stall on RAW or WAW hazards at decode.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int RS_W     = RS_WIDTH,
    parameter int NUM_RD   = 2,
    parameter int MAX_LAT  = 7,
    localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*RS_W-1:0] rs_id,
    input  logic                   issue_valid,
    input  logic                   issue_regwrite,
    input  logic [RS_W-1:0]        issue_rd,
    input  logic [LAT_W-1:0]       issue_lat,
    input  logic                   wb_valid,
    input  logic [RS_W-1:0]        wb_rd,
    input  logic                   flush,
    output logic [NUM_RD*2-1:0]    fwd_sel,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy,
    output logic [31:0]            stall_cnt
);

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    logic [NUM_REGS-1:0] pend_v;
    logic [LAT_W-1:0]    cnt_v [NUM_REGS];
    logic [LAT_W-1:0]    lat_clamped;
    logic                load_ok;
    logic                raw_hazard;
    logic                waw_hazard;
    logic [RS_W-1:0]     rs;
    fwd_sel_e            sel;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    assign lat_clamped = (issue_lat > MAX_LAT_V) ? MAX_LAT_V : issue_lat;
    assign load_ok     = issue_valid & issue_regwrite & (issue_rd != '0) & ~stall & ~flush;

    // x0 is hardwired: never pending, so it always reads from the register file.
    assign pend_v[0] = 1'b0;
    assign cnt_v[0]  = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load_ok && (issue_rd == RS_W'(r))),
            .lat_i    (lat_clamped),
            .wb_clr_i (wb_valid && (wb_rd == RS_W'(r))),
            .flush_i  (flush),
            .pend_o   (pend_v[r]),
            .cnt_o    (cnt_v[r])
        );
    end

    always_comb begin
        fwd_sel    = '0;
        raw_hazard = 1'b0;
        rs         = '0;
        sel        = FWD_RF;
        for (int i = 0; i < NUM_RD; i++) begin
            rs  = rs_id[i*RS_W +: RS_W];
            sel = fwd_decode(pend_v[rs], cnt_v[rs] == '0);
            fwd_sel[i*2 +: 2] = sel;
            if (sel == FWD_WAIT) raw_hazard = 1'b1;
        end
    end

    assign waw_hazard = issue_regwrite && (issue_rd != '0) && pend_v[issue_rd] &&
                        (cnt_v[issue_rd] != '0);
    assign stall      = issue_valid && !flush && (raw_hazard || waw_hazard);

    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign busy      = pend_v;
    assign stall_cnt = stall_cnt_q;

endmodule
